// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
//
// if_fetch_unit_fifo: small circular FIFO with synchronous flush.
//    clk, rst         clock, synchronous active-high reset
//    flush            empty the FIFO (pointers and count cleared)
//    push, push_data  write one entry
//    pop              drop the head entry (caller never pops when empty)
//    count            number of entries held
//    head_data        oldest entry (undefined when count is zero)
//
// if_fetch_unit: owns the PC, issues in-order fetches, queues the returned
// instructions and presents one per cycle with its address.
//    clk, rst                        clock, synchronous active-high reset
//    hold_in                         IF/ID not accepting this cycle
//    jump_en, jump_addr              redirect; target forced word aligned
//    imem_req_valid/ready/addr       fetch request handshake
//    imem_rsp_valid, imem_rsp_data   in-order fetch response, never stalled
//    inst_valid, inst_out,
//    inst_addr_out                   queue head; NOP_INST / 0 when empty

module if_fetch_unit_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head_data
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: slots are only observed while count says valid.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_in,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_addr_out
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   CREDIT  = (CW + 1)'(DEPTH);

   logic [31:0]   pc;
   logic [31:0]   jump_target;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] q_count;
   logic [CW:0]   in_use;
   logic [31:0]   pend_addr;
   logic [63:0]   q_head;
   logic          req_fire;
   logic          q_push;
   logic          q_pop;

   assign jump_target = jump_addr & 32'hFFFF_FFFC;

   // Head leaves toward IF/ID this cycle; a redirect flushes it instead.
   assign q_pop = inst_valid && !hold_in && !jump_en;

   // Slots in use counting requests in flight plus queued entries. The entry
   // leaving this cycle frees its slot immediately, which is what lets a
   // two-entry design sustain one fetch per cycle with single-cycle memory;
   // under hold nothing leaves and the queue simply fills.
   assign in_use = {1'b0, outstanding} + {1'b0, q_count} - {{CW{1'b0}}, q_pop};

   assign imem_req_valid = !rst && !jump_en && (in_use < CREDIT);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response is kept only when no stale fetches remain to be dropped and
   // no redirect is happening in the same cycle.
   assign q_push = imem_rsp_valid && (discard == '0) && !jump_en;

   // Addresses of accepted requests, consumed one per response. Its
   // occupancy is the number of requests still outstanding; it is not
   // flushed on redirect because stale responses still arrive.
   if_fetch_unit_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_addr_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (pc),
      .pop       (imem_rsp_valid),
      .count     (outstanding),
      .head_data (pend_addr)
   );

   // Returned instructions tagged with their fetch address.
   if_fetch_unit_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (jump_en),
      .push      (q_push),
      .push_data ({pend_addr, imem_rsp_data}),
      .pop       (q_pop),
      .count     (q_count),
      .head_data (q_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (jump_en) begin
         pc <= jump_target;
      end else if (req_fire) begin
         pc <= pc + 32'd4;
      end
   end

   // On redirect every fetch still in flight after this cycle is stale; a
   // response arriving in the redirect cycle is already dropped by q_push.
   always_ff @(posedge clk) begin
      if (rst) begin
         discard <= '0;
      end else if (jump_en) begin
         discard <= imem_rsp_valid ? (outstanding - CNT_ONE) : outstanding;
      end else if (imem_rsp_valid && (discard != '0)) begin
         discard <= discard - CNT_ONE;
      end
   end

   assign inst_valid    = (q_count != '0);
   assign inst_out      = inst_valid ? q_head[31:0]  : NOP_INST;
   assign inst_addr_out = inst_valid ? q_head[63:32] : 32'h0000_0000;

endmodule
